// File: rtl/frame_scanout.sv
// frame_scanout: LCD timing generator and frame-buffer reader.
// Walks the panel raster on clk_33m, fetches 2-bit palette indices from the
// displayed half of a double-buffered frame RAM, expands them to 24-bit RGB,
// and owns the buffer-swap handshake with the paint controller.
// Pipeline: counters -> RAM address (stage 0) -> RAM data (stage 1) -> pins (stage 2).
module frame_scanout #(
    parameter int unsigned COOR_WIDTH   = 12,
    parameter int unsigned FRAME_WIDTH  = 1280,
    parameter int unsigned FRAME_HEIGHT = 300,
    parameter int unsigned FRAME_TOP    = 90,
    parameter int unsigned H_ACTIVE     = 800,
    parameter int unsigned H_FP         = 40,
    parameter int unsigned H_SYNC       = 48,
    parameter int unsigned H_BP         = 40,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 13,
    parameter int unsigned V_SYNC       = 3,
    parameter int unsigned V_BP         = 29,
    parameter logic [23:0] PAL0         = 24'hF7F7F7,
    parameter logic [23:0] PAL1         = 24'h535353,
    parameter logic [23:0] PAL2         = 24'hDADADA,
    parameter logic [23:0] PAL3         = 24'hFFFFFF
) (
    input  logic                  clk_33m,
    input  logic                  rst_n,
    input  logic [COOR_WIDTH-1:0] view_x,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  read_buf,
    output logic                  read_en,
    output logic [COOR_WIDTH-1:0] read_x,
    output logic [COOR_WIDTH-1:0] read_y,
    input  logic [1:0]            read_palette,
    output logic [7:0]            video_r,
    output logic [7:0]            video_g,
    output logic [7:0]            video_b,
    output logic                  video_hsync,
    output logic                  video_vsync,
    output logic                  video_de,
    output logic                  frame_start
);

    localparam int unsigned CW      = COOR_WIDTH;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] F_TOP_C  = CW'(FRAME_TOP);
    localparam logic [CW-1:0] F_BOT_C  = CW'(FRAME_TOP + FRAME_HEIGHT);
    localparam logic [CW-1:0] VX_MAX   = CW'(FRAME_WIDTH - H_ACTIVE);
    localparam logic [CW:0]   F_WID_C  = (CW + 1)'(FRAME_WIDTH);

    // Raster counters
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;

    // Per-frame control state
    logic [CW-1:0] vx_q, vx_d;
    logic          read_buf_q, read_buf_d;
    logic          swap_ack_q, swap_ack_d;
    logic          frame_start_q, frame_start_d;

    // Stage 0 (combinational from counters)
    logic          active_s0;
    logic          in_frame_s0;
    logic          hsync_s0;
    logic          vsync_s0;
    logic          vblank_s0;
    logic [CW:0]   fx_s0;
    logic [CW-1:0] vx_clamped;

    // Stage 1 (aligned with RAM data)
    logic active_s1_q;
    logic in_frame_s1_q;
    logic hsync_s1_q;
    logic vsync_s1_q;

    // Stage 2 (pin registers)
    logic [23:0] pal_rgb;
    logic [23:0] rgb_q, rgb_d;
    logic        de_q;
    logic        hsync_q;
    logic        vsync_q;

    // Next raster position: h wraps at end of line, v advances on h wrap
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d = '0;
            end else begin
                v_d = v_q + 1'b1;
            end
        end
    end

    // Raster counter registers
    always_ff @(posedge clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Stage 0: visibility, frame window, RAM address and raw sync levels
    always_comb begin
        active_s0   = (h_q < H_ACT_C) && (v_q < V_ACT_C);
        fx_s0       = {1'b0, vx_q} + {1'b0, h_q};
        in_frame_s0 = active_s0 && (v_q >= F_TOP_C) && (v_q < F_BOT_C) && (fx_s0 < F_WID_C);
        hsync_s0    = !((h_q >= HS_BEG) && (h_q < HS_END));
        vsync_s0    = !((v_q >= VS_BEG) && (v_q < VS_END));
        vblank_s0   = (h_q == '0) && (v_q == V_ACT_C);
        read_en     = in_frame_s0;
        read_x      = in_frame_s0 ? fx_s0[CW-1:0] : '0;
        read_y      = in_frame_s0 ? (v_q - F_TOP_C) : '0;
    end

    // Viewport clamp keeps the visible window inside the frame RAM
    always_comb begin
        vx_clamped = (view_x > VX_MAX) ? VX_MAX : view_x;
    end

    // Vblank-start bookkeeping: frame pulse, viewport latch, buffer swap
    always_comb begin
        vx_d          = vx_q;
        read_buf_d    = read_buf_q;
        swap_ack_d    = 1'b0;
        frame_start_d = vblank_s0;
        if (vblank_s0) begin
            vx_d = vx_clamped;
            if (swap_req) begin
                read_buf_d = !read_buf_q;
                swap_ack_d = 1'b1;
            end
        end
    end

    // Control registers; read_buf only moves on the vblank-start edge
    always_ff @(posedge clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            vx_q          <= '0;
            read_buf_q    <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            vx_q          <= vx_d;
            read_buf_q    <= read_buf_d;
            swap_ack_q    <= swap_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Stage 1: carry qualifiers and syncs alongside the RAM read latency
    always_ff @(posedge clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            active_s1_q   <= 1'b0;
            in_frame_s1_q <= 1'b0;
            hsync_s1_q    <= 1'b1;
            vsync_s1_q    <= 1'b1;
        end else begin
            active_s1_q   <= active_s0;
            in_frame_s1_q <= in_frame_s0;
            hsync_s1_q    <= hsync_s0;
            vsync_s1_q    <= vsync_s0;
        end
    end

    // Palette lookup of the returned RAM index
    always_comb begin
        pal_rgb = PAL0;
        case (read_palette)
            2'd0:    pal_rgb = PAL0;
            2'd1:    pal_rgb = PAL1;
            2'd2:    pal_rgb = PAL2;
            default: pal_rgb = PAL3;
        endcase
    end

    // Pixel colour: frame data, background outside the frame window, black in blanking
    always_comb begin
        rgb_d = '0;
        if (in_frame_s1_q) begin
            rgb_d = pal_rgb;
        end else if (active_s1_q) begin
            rgb_d = PAL0;
        end
    end

    // Stage 2: pin registers
    always_ff @(posedge clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= '0;
            de_q    <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            de_q    <= active_s1_q;
            hsync_q <= hsync_s1_q;
            vsync_q <= vsync_s1_q;
        end
    end

    assign video_r     = rgb_q[23:16];
    assign video_g     = rgb_q[15:8];
    assign video_b     = rgb_q[7:0];
    assign video_de    = de_q;
    assign video_hsync = hsync_q;
    assign video_vsync = vsync_q;
    assign swap_ack    = swap_ack_q;
    assign read_buf    = read_buf_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout on a reduced raster geometry (52x31 total) so several
// frames fit in a short run. A position-from-cycle-count reference model gives
// the expected value of every pin on every cycle.
module tb_frame_scanout;

    localparam int CW   = 12;
    localparam int FW   = 64;
    localparam int FH   = 10;
    localparam int FTOP = 6;
    localparam int HA   = 40;
    localparam int HFP  = 4;
    localparam int HS   = 5;
    localparam int HBP  = 3;
    localparam int VA   = 24;
    localparam int VFP  = 2;
    localparam int VS   = 2;
    localparam int VBP  = 3;
    localparam int HT   = HA + HFP + HS + HBP;
    localparam int VT   = VA + VFP + VS + VBP;
    localparam int FT   = HT * VT;
    localparam int VXMAX = FW - HA;

    localparam logic [54:0] RST_PINS = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b0};

    logic          clk_33m = 1'b0;
    logic          rst_n;
    logic [CW-1:0] view_x;
    logic          swap_req;
    logic          swap_ack;
    logic          read_buf;
    logic          read_en;
    logic [CW-1:0] read_x;
    logic [CW-1:0] read_y;
    logic [1:0]    read_palette = 2'd0;
    logic [7:0]    video_r, video_g, video_b;
    logic          video_hsync, video_vsync, video_de;
    logic          frame_start;

    frame_scanout #(
        .COOR_WIDTH(CW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .FRAME_TOP(FTOP),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk_33m(clk_33m), .rst_n(rst_n), .view_x(view_x),
        .swap_req(swap_req), .swap_ack(swap_ack), .read_buf(read_buf),
        .read_en(read_en), .read_x(read_x), .read_y(read_y), .read_palette(read_palette),
        .video_r(video_r), .video_g(video_g), .video_b(video_b),
        .video_hsync(video_hsync), .video_vsync(video_vsync), .video_de(video_de),
        .frame_start(frame_start)
    );

    always #5 clk_33m = ~clk_33m;

    logic [54:0] pins;
    assign pins = {video_r, video_g, video_b, video_hsync, video_vsync, video_de,
                   read_en, read_x, read_y, frame_start, swap_ack, read_buf};

    int n_assert = 0;
    int n_fail   = 0;
    int bad;
    int bad_k;
    logic [54:0] bad_got, bad_exp;

    // Frame RAM contents: both buffers hold distinct index patterns
    function automatic logic [1:0] ram_idx(logic b, int x, int y);
        int s;
        s = x + 3 * y + 2 * int'(b);
        return s[1:0];
    endfunction

    function automatic logic [23:0] pal_of(logic [1:0] i);
        case (i)
            2'd0:    return 24'hF7F7F7;
            2'd1:    return 24'h535353;
            2'd2:    return 24'hDADADA;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    // Synchronous-read RAM; garbage when not strobed
    always @(posedge clk_33m)
        read_palette <= read_en ? ram_idx(read_buf, int'(read_x), int'(read_y)) : 2'($urandom);

    // Reference model state: m_k = clock edges since reset release
    int   m_k;
    int   m_vx;
    logic m_buf, m_fs, m_ack;

    function automatic bit is_vb(int k);
        return (k % HT == 0) && ((k / HT) % VT == VA);
    endfunction

    always @(posedge clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            m_k <= 0; m_vx <= 0; m_buf <= 1'b0; m_fs <= 1'b0; m_ack <= 1'b0;
        end else begin
            m_k   <= m_k + 1;
            m_fs  <= is_vb(m_k);
            m_ack <= is_vb(m_k) && swap_req;
            if (is_vb(m_k)) begin
                m_vx <= (int'(view_x) > VXMAX) ? VXMAX : int'(view_x);
                if (swap_req) m_buf <= ~m_buf;
            end
        end
    end

    // Expected pins: address side follows the raster now, pixel side two cycles behind
    function automatic logic [54:0] exp_pins();
        int h, v, x;
        logic en, de, hs, vs;
        logic [11:0] rx, ry;
        logic [23:0] rgb;
        h  = m_k % HT;
        v  = (m_k / HT) % VT;
        x  = m_vx + h;
        en = (h < HA) && (v < VA) && (v >= FTOP) && (v < FTOP + FH) && (x < FW);
        rx = en ? 12'(x) : 12'h0;
        ry = en ? 12'(v - FTOP) : 12'h0;
        rgb = 24'h0; de = 1'b0; hs = 1'b1; vs = 1'b1;
        if (m_k >= 2) begin
            h  = (m_k - 2) % HT;
            v  = ((m_k - 2) / HT) % VT;
            x  = m_vx + h;
            de = (h < HA) && (v < VA);
            hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
            vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
            if (de)
                rgb = ((v >= FTOP) && (v < FTOP + FH) && (x < FW)) ?
                      pal_of(ram_idx(m_buf, x, v - FTOP)) : 24'hF7F7F7;
        end
        return {rgb, hs, vs, de, en, rx, ry, m_fs, m_ack, m_buf};
    endfunction

    // Advance one cycle and tally any pin disagreement with the model
    task automatic tick();
        logic [54:0] e;
        @(negedge clk_33m);
        e = exp_pins();
        if (pins !== e) begin
            if (bad == 0) begin bad_k = m_k; bad_got = pins; bad_exp = e; end
            bad++;
        end
    endtask

    task automatic wait_pos(int h, int v);
        for (int i = 0; i < FT + 2; i++) begin
            if ((m_k % HT == h) && ((m_k / HT) % VT == v)) return;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; view_x = '0; swap_req = 1'b0;
        repeat (3) @(posedge clk_33m);
        #1;
        n_assert++;
        if (pins !== RST_PINS) begin
            n_fail++; $display("FAIL reset_values: got=%h exp=%h", pins, RST_PINS);
        end
        @(negedge clk_33m);
        rst_n = 1'b1;
    endtask

    task automatic test_timing();
        int fs1, fs2, de_cnt, hs_cnt, vs_cnt;
        bad = 0; fs1 = -1; fs2 = -1; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        for (int i = 0; i < 2 * FT + 8 && fs2 < 0; i++) begin
            tick();
            if (frame_start === 1'b1) begin
                if (fs1 < 0) fs1 = m_k; else fs2 = m_k;
            end
            if (fs1 >= 0 && fs2 < 0) begin
                de_cnt += int'(video_de === 1'b1);
                hs_cnt += int'(video_hsync === 1'b0);
                vs_cnt += int'(video_vsync === 1'b0);
            end
        end
        n_assert++;
        if (fs1 != VA * HT + 1) begin n_fail++; $display("FAIL first_frame_start: cycle=%0d exp=%0d", fs1, VA * HT + 1); end
        n_assert++;
        if (fs2 - fs1 != FT) begin n_fail++; $display("FAIL frame_period: got=%0d exp=%0d", fs2 - fs1, FT); end
        n_assert++;
        if (de_cnt != HA * VA) begin n_fail++; $display("FAIL de_count: got=%0d exp=%0d", de_cnt, HA * VA); end
        n_assert++;
        if (hs_cnt != HS * VT) begin n_fail++; $display("FAIL hsync_low_count: got=%0d exp=%0d", hs_cnt, HS * VT); end
        n_assert++;
        if (vs_cnt != VS * HT) begin n_fail++; $display("FAIL vsync_low_count: got=%0d exp=%0d", vs_cnt, VS * HT); end
        n_assert++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL timing_model: %0d bad cycles, first k=%0d got=%h exp=%h", bad, bad_k, bad_got, bad_exp);
        end
    endtask

    task automatic test_view();
        int req, req2;
        bad = 0;
        req = VXMAX + int'($urandom_range(1, 200));
        view_x = 12'(req);
        wait_pos(0, VA);
        wait_pos(0, FTOP);
        n_assert++;
        if (read_x !== 12'(VXMAX) || read_en !== 1'b1) begin
            n_fail++; $display("FAIL view_clamp: read_x=%0d read_en=%b exp=%0d/1", read_x, read_en, VXMAX);
        end
        wait_pos(0, FTOP + 2);
        req2 = int'($urandom_range(0, VXMAX));
        view_x = 12'(req2);
        wait_pos(0, FTOP + 3);
        n_assert++;
        if (read_x !== 12'(VXMAX)) begin
            n_fail++; $display("FAIL view_midframe_hold: read_x=%0d exp=%0d", read_x, VXMAX);
        end
        wait_pos(0, VA);
        wait_pos(HA - 1, FTOP);
        n_assert++;
        if (read_x !== 12'(req2 + HA - 1)) begin
            n_fail++; $display("FAIL view_new_frame: read_x=%0d exp=%0d", read_x, req2 + HA - 1);
        end
        wait_pos(0, VA);
        n_assert++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL view_model: %0d bad cycles, first k=%0d got=%h exp=%h", bad, bad_k, bad_got, bad_exp);
        end
    endtask

    task automatic test_swap_single();
        int ack_k, acks;
        bad = 0; ack_k = -1; acks = 0;
        wait_pos(0, 10);
        swap_req = 1'b1;
        for (int i = 0; i < FT + 8 && ack_k < 0; i++) begin
            tick();
            if (swap_ack === 1'b1) ack_k = m_k;
        end
        swap_req = 1'b0;
        n_assert++;
        if ((ack_k - 1) % FT != VA * HT) begin
            n_fail++; $display("FAIL swap_ack_position: pos=%0d exp=%0d", (ack_k - 1) % FT, VA * HT);
        end
        n_assert++;
        if (read_buf !== 1'b1) begin n_fail++; $display("FAIL swap_toggle: read_buf=%b exp=1", read_buf); end
        for (int i = 0; i < FT; i++) begin
            tick();
            if (swap_ack === 1'b1) acks++;
        end
        n_assert++;
        if (acks != 0) begin n_fail++; $display("FAIL swap_no_request: acks=%0d exp=0", acks); end
        n_assert++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL swap_single_model: %0d bad cycles, first k=%0d got=%h exp=%h", bad, bad_k, bad_got, bad_exp);
        end
    endtask

    task automatic test_midreset();
        int de_first;
        n_assert++;
        if (read_buf !== 1'b1) begin n_fail++; $display("FAIL pre_reset_buf: read_buf=%b exp=1", read_buf); end
        bad = 0;
        wait_pos(20, 10);
        #2 rst_n = 1'b0;
        #1;
        n_assert++;
        if (pins !== RST_PINS) begin n_fail++; $display("FAIL async_reset: got=%h exp=%h", pins, RST_PINS); end
        repeat (3) @(posedge clk_33m);
        @(negedge clk_33m);
        rst_n = 1'b1;
        n_assert++;
        if (read_buf !== 1'b0) begin n_fail++; $display("FAIL reset_buf: read_buf=%b exp=0", read_buf); end
        de_first = -1;
        for (int i = 0; i < FT + 4; i++) begin
            tick();
            if (video_de === 1'b1 && de_first < 0) de_first = m_k;
        end
        n_assert++;
        if (de_first != 2) begin n_fail++; $display("FAIL first_de: cycle=%0d exp=2", de_first); end
        n_assert++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL midreset_model: %0d bad cycles, first k=%0d got=%h exp=%h", bad, bad_k, bad_got, bad_exp);
        end
    endtask

    task automatic test_swap_double();
        int acks, extra;
        bad = 0; acks = 0; extra = 0;
        wait_pos(0, 10);
        swap_req = 1'b1;
        for (int i = 0; i < 2 * FT + 8 && acks < 2; i++) begin
            tick();
            if (swap_ack === 1'b1) acks++;
        end
        swap_req = 1'b0;
        n_assert++;
        if (acks != 2) begin n_fail++; $display("FAIL swap_double_acks: got=%0d exp=2", acks); end
        n_assert++;
        if (read_buf !== 1'b0) begin n_fail++; $display("FAIL swap_double_buf: read_buf=%b exp=0", read_buf); end
        for (int i = 0; i < FT; i++) begin
            tick();
            if (swap_ack === 1'b1) extra++;
        end
        n_assert++;
        if (extra != 0) begin n_fail++; $display("FAIL swap_after_drop: acks=%0d exp=0", extra); end
        n_assert++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL swap_double_model: %0d bad cycles, first k=%0d got=%h exp=%h", bad, bad_k, bad_got, bad_exp);
        end
    endtask

    task automatic test_swap_edge();
        bad = 0;
        wait_pos(0, VA);
        swap_req = 1'b1;
        tick();
        n_assert++;
        if ({swap_ack, frame_start, read_buf} !== 3'b111) begin
            n_fail++; $display("FAIL swap_same_cycle: ack/fs/buf=%b exp=111", {swap_ack, frame_start, read_buf});
        end
        swap_req = 1'b0;
        tick();
        n_assert++;
        if (swap_ack !== 1'b0) begin n_fail++; $display("FAIL swap_ack_width: swap_ack=%b exp=0", swap_ack); end
        repeat (HT) tick();
        n_assert++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL swap_edge_model: %0d bad cycles, first k=%0d got=%h exp=%h", bad, bad_k, bad_got, bad_exp);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timing();
        test_view();
        test_swap_single();
        test_midreset();
        test_swap_double();
        test_swap_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
